// File: rtl/sim_jtag_bitbang.sv
// -----------------------------------------------------------------------------
// sim_jtag_bitbang
//
// Multi-channel JTAG bit-bang driver for simulation harnesses. A host-side
// agent sends one pin command per tick over a valid/ready port. The block
// applies the pins to one of CHANNELS JTAG ports and holds them for
// TICK_DELAY+1 cycles. It can also sample TDO into a first-word-fall-through
// response FIFO.
//
// Ports
//   clock_i, reset_i        clock; asynchronous active-high reset
//   enable_i                level; gates command acceptance, freezes the hold
//   init_done_i             pulse or level, remembered internally
//   cmd_valid_i/cmd_ready_o command handshake
//   cmd_chan_i              target channel
//   cmd_tck/tms/tdi/trstn_i pin values to apply
//   cmd_sample_i            capture TDO at the end of the hold
//   cmd_exit_i              command is an exit request (pin fields ignored)
//   cmd_exit_code_i         exit value, used only for exit requests
//   rsp_valid_o/rsp_ready_i response pop handshake
//   rsp_tdo_o, rsp_chan_o   head entry: sampled TDO bit and its channel
//   rsp_count_o             FIFO occupancy
//   jtag_TCK/TMS/TDI/TRSTn_o per-channel registered pins
//   jtag_TDO_data_i/_driven_i per-channel TDO value and driven flag
//   exit_o                  sticky exit code, 0 while running
// -----------------------------------------------------------------------------
module sim_jtag_bitbang #(
    parameter int          CHANNELS   = 2,
    parameter int          TICK_DELAY = 50,
    parameter int          RSP_DEPTH  = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int         RCW        = $clog2(RSP_DEPTH + 1)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                init_done_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [CW-1:0]       cmd_chan_i,
    input  logic                cmd_tck_i,
    input  logic                cmd_tms_i,
    input  logic                cmd_tdi_i,
    input  logic                cmd_trstn_i,
    input  logic                cmd_sample_i,
    input  logic                cmd_exit_i,
    input  logic [31:0]         cmd_exit_code_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_tdo_o,
    output logic [CW-1:0]       rsp_chan_o,
    output logic [RCW-1:0]      rsp_count_o,
    output logic [CHANNELS-1:0] jtag_TCK_o,
    output logic [CHANNELS-1:0] jtag_TMS_o,
    output logic [CHANNELS-1:0] jtag_TDI_o,
    output logic [CHANNELS-1:0] jtag_TRSTn_o,
    input  logic [CHANNELS-1:0] jtag_TDO_data_i,
    input  logic [CHANNELS-1:0] jtag_TDO_driven_i,
    output logic [31:0]         exit_o
);

    localparam int HW   = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam int PW   = $clog2(RSP_DEPTH);
    localparam int NPAD = 1 << CW;
    localparam int EW   = CW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            init_q;
    logic [31:0]     exit_q;
    logic [15:0]     lfsr_q;
    logic            lfsr_fb;
    logic [HW-1:0]   hold_cnt_q;
    logic [CW-1:0]   chan_q;
    logic            sample_q;

    logic            cmd_ready;
    logic            accept;
    logic            accept_pins;
    logic            accept_exit;
    logic            hold_done;
    logic            push;
    logic            pop;
    logic            fifo_full;

    logic [NPAD-1:0] tdo_pad;
    logic            tdo_sample;

    logic [EW-1:0]   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [RCW-1:0]  count_q;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    assign pop       = (count_q != '0) & rsp_ready_i;
    assign fifo_full = (count_q == RCW'(RSP_DEPTH));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_pins) state_d = ST_HOLD;
            ST_HOLD: if (hold_done)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO keeps the FSM in HOLD. TDO is re-sampled every cycle until
    // a slot frees up. A same-cycle pop counts as a free slot.
    always_comb begin
        cmd_ready = 1'b0;
        hold_done = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = enable_i & init_q & (exit_q == 32'd0);
            ST_HOLD: begin
                if (enable_i && (hold_cnt_q == '0)) begin
                    if (!sample_q) begin
                        hold_done = 1'b1;
                    end else if (!fifo_full || pop) begin
                        push      = 1'b1;
                        hold_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign accept      = cmd_ready & cmd_valid_i;
    assign accept_pins = accept & ~cmd_exit_i;
    assign accept_exit = accept & cmd_exit_i & (cmd_exit_code_i != 32'd0);

    // ----------------------------------------------------- control state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            init_q     <= 1'b0;
            exit_q     <= 32'd0;
            lfsr_q     <= LFSR_SEED;
            hold_cnt_q <= '0;
            chan_q     <= '0;
            sample_q   <= 1'b0;
        end else begin
            init_q <= init_q | init_done_i;
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
            if (accept_exit) begin
                exit_q <= cmd_exit_code_i;
            end
            if (accept_pins) begin
                hold_cnt_q <= HW'(TICK_DELAY);
                chan_q     <= cmd_chan_i;
                sample_q   <= cmd_sample_i;
            end else if ((state_q == ST_HOLD) && enable_i && (hold_cnt_q != '0)) begin
                hold_cnt_q <= hold_cnt_q - HW'(1);
            end
        end
    end

    // ------------------------------------------------ per-channel pins
    // Out-of-range channel numbers match no channel, so no pins change.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic tck_q, tms_q, tdi_q, trstn_q;

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                tck_q   <= 1'b0;
                tms_q   <= 1'b0;
                tdi_q   <= 1'b0;
                trstn_q <= 1'b0;
            end else if (accept_pins && (cmd_chan_i == CW'(gi))) begin
                tck_q   <= cmd_tck_i;
                tms_q   <= cmd_tms_i;
                tdi_q   <= cmd_tdi_i;
                trstn_q <= cmd_trstn_i;
            end
        end

        assign jtag_TCK_o[gi]   = tck_q;
        assign jtag_TMS_o[gi]   = tms_q;
        assign jtag_TDI_o[gi]   = tdi_q;
        assign jtag_TRSTn_o[gi] = trstn_q;
    end

    // TDO source per channel index. The vector is padded to the full
    // channel-number range, so unused numbers sample as 0.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_tdo
        if (gi < CHANNELS) begin : g_real
            assign tdo_pad[gi] = jtag_TDO_driven_i[gi] ? jtag_TDO_data_i[gi] : lfsr_q[0];
        end else begin : g_none
            assign tdo_pad[gi] = 1'b0;
        end
    end

    assign tdo_sample = tdo_pad[chan_q];

    // ------------------------------------------------- response FIFO
    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {tdo_sample, chan_q};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + RCW'(1);
                2'b01:   count_q <= count_q - RCW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rsp_valid_o = (count_q != '0);
    assign rsp_tdo_o   = fifo_mem[rd_ptr_q][CW];
    assign rsp_chan_o  = fifo_mem[rd_ptr_q][CW-1:0];
    assign rsp_count_o = count_q;
    assign cmd_ready_o = cmd_ready;
    assign exit_o      = exit_q;

endmodule

// File: tb/tb_sim_jtag_bitbang.sv
// -----------------------------------------------------------------------------
// tb_sim_jtag_bitbang
//
// Directed bench for sim_jtag_bitbang configured with CHANNELS=2,
// TICK_DELAY=3 and RSP_DEPTH=2. Each scenario is a task with inline checks.
// Expected values are worked out by hand. The undriven-TDO samples are checked
// against a golden LFSR model.
// -----------------------------------------------------------------------------
module tb_sim_jtag_bitbang;

    localparam int          CH   = 2;
    localparam int          TD   = 3;
    localparam int          RD   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_chan = 1'b0;
    logic        cmd_tck = 1'b0, cmd_tms = 1'b0, cmd_tdi = 1'b0, cmd_trstn = 1'b0;
    logic        cmd_sample = 1'b0;
    logic        cmd_exit = 1'b0;
    logic [31:0] cmd_exit_code = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_tdo;
    logic [0:0]  rsp_chan;
    logic [1:0]  rsp_count;
    logic [1:0]  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic [1:0]  tdo_data = 2'b00;
    logic [1:0]  tdo_driven = 2'b00;
    logic [31:0] exit_val;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sim_jtag_bitbang #(
        .CHANNELS   (CH),
        .TICK_DELAY (TD),
        .RSP_DEPTH  (RD),
        .LFSR_SEED  (SEED)
    ) dut (
        .clock_i           (clock),
        .reset_i           (reset),
        .enable_i          (enable),
        .init_done_i       (init_done),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_chan_i        (cmd_chan),
        .cmd_tck_i         (cmd_tck),
        .cmd_tms_i         (cmd_tms),
        .cmd_tdi_i         (cmd_tdi),
        .cmd_trstn_i       (cmd_trstn),
        .cmd_sample_i      (cmd_sample),
        .cmd_exit_i        (cmd_exit),
        .cmd_exit_code_i   (cmd_exit_code),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_tdo_o         (rsp_tdo),
        .rsp_chan_o        (rsp_chan),
        .rsp_count_o       (rsp_count),
        .jtag_TCK_o        (jtag_TCK),
        .jtag_TMS_o        (jtag_TMS),
        .jtag_TDI_o        (jtag_TDI),
        .jtag_TRSTn_o      (jtag_TRSTn),
        .jtag_TDO_data_i   (tdo_data),
        .jtag_TDO_driven_i (tdo_driven),
        .exit_o            (exit_val)
    );

    // Golden LFSR: lfsr_prev holds the value in force before the latest edge.
    logic [15:0] lfsr_m, lfsr_prev;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_m    <= SEED;
            lfsr_prev <= SEED;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_init();
        enable = 1'b1;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
    endtask

    // Present a command, wait (bounded) for cmd_ready, then let one edge accept it.
    // Returns at #1 after the accepting edge.
    task automatic issue(input logic ch, input logic tck, input logic tms, input logic tdi,
                         input logic trstn, input logic smp, input logic ex,
                         input logic [31:0] code);
        int n;
        cmd_chan = ch; cmd_tck = tck; cmd_tms = tms; cmd_tdi = tdi; cmd_trstn = trstn;
        cmd_sample = smp; cmd_exit = ex; cmd_exit_code = code;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b required 1 within 40 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_exit = 1'b0;
        cmd_sample = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++; if (jtag_TCK !== 2'b00)   begin errors++; $display("FAIL reset_tck: got %b required 00", jtag_TCK); end
        checks++; if (jtag_TMS !== 2'b00)   begin errors++; $display("FAIL reset_tms: got %b required 00", jtag_TMS); end
        checks++; if (jtag_TDI !== 2'b00)   begin errors++; $display("FAIL reset_tdi: got %b required 00", jtag_TDI); end
        checks++; if (jtag_TRSTn !== 2'b00) begin errors++; $display("FAIL reset_trstn: got %b required 00", jtag_TRSTn); end
        checks++; if (exit_val !== 32'd0)   begin errors++; $display("FAIL reset_exit: got %0h required 0", exit_val); end
        checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_count !== 2'd0)   begin errors++; $display("FAIL reset_rsp_count: got %0d required 0", rsp_count); end
        checks++; if (cmd_ready !== 1'b0)   begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_init: got %b required 0", cmd_ready); end
        pulse_init();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_init: got %b required 1", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL init_sticky: got %b required 1", cmd_ready); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int low;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (jtag_TCK !== 2'b10)   begin errors++; $display("FAIL basic_tck: got %b required 10", jtag_TCK); end
        checks++; if (jtag_TMS !== 2'b10)   begin errors++; $display("FAIL basic_tms: got %b required 10", jtag_TMS); end
        checks++; if (jtag_TDI !== 2'b00)   begin errors++; $display("FAIL basic_tdi: got %b required 00", jtag_TDI); end
        checks++; if (jtag_TRSTn !== 2'b10) begin errors++; $display("FAIL basic_trstn: got %b required 10", jtag_TRSTn); end
        low = 0;
        while (!cmd_ready && low < 20) begin
            low++;
            tick();
        end
        checks++; if (low != TD + 1) begin errors++; $display("FAIL basic_hold_cycles: got %0d required %0d", low, TD + 1); end
        checks++; if (jtag_TCK !== 2'b10) begin errors++; $display("FAIL basic_tck_held: got %b required 10", jtag_TCK); end
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (jtag_TCK !== 2'b11)   begin errors++; $display("FAIL basic2_tck: got %b required 11", jtag_TCK); end
        checks++; if (jtag_TMS !== 2'b10)   begin errors++; $display("FAIL basic2_tms: got %b required 10", jtag_TMS); end
        checks++; if (jtag_TDI !== 2'b01)   begin errors++; $display("FAIL basic2_tdi: got %b required 01", jtag_TDI); end
        checks++; if (jtag_TRSTn !== 2'b11) begin errors++; $display("FAIL basic2_trstn: got %b required 11", jtag_TRSTn); end
        $display("test_basic done: hold low cycles=%0d", low);
    endtask

    task automatic test_sample_driven();
        logic       t_ch  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] t_drv [4] = '{2'b01, 2'b11, 2'b11, 2'b11};
        logic [1:0] t_dat [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic       t_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 4; i++) begin
            tdo_driven = t_drv[i];
            tdo_data   = t_dat[i];
            issue(t_ch[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            checks++; if (n != TD + 1)        begin errors++; $display("FAIL drv%0d_latency: got %0d required %0d", i, n, TD + 1); end
            checks++; if (rsp_tdo !== t_exp[i]) begin errors++; $display("FAIL drv%0d_tdo: got %b required %b", i, rsp_tdo, t_exp[i]); end
            checks++; if (rsp_chan !== t_ch[i]) begin errors++; $display("FAIL drv%0d_chan: got %b required %b", i, rsp_chan, t_ch[i]); end
            checks++; if (rsp_count !== 2'd1)   begin errors++; $display("FAIL drv%0d_count: got %0d required 1", i, rsp_count); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checks++; if (rsp_count !== 2'd0) begin errors++; $display("FAIL drv%0d_pop: got %0d required 0", i, rsp_count); end
            $display("sample driven ch=%0d tdo=%b", t_ch[i], rsp_tdo);
        end
    endtask

    task automatic test_sample_lfsr();
        int n;
        logic ch;
        tdo_driven = 2'b00;
        tdo_data   = 2'b11;
        for (int i = 0; i < 8; i++) begin
            ch = i[0];
            issue(ch, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            checks++; if (rsp_valid !== 1'b1)       begin errors++; $display("FAIL lfsr%0d_valid: got %b required 1", i, rsp_valid); end
            checks++; if (rsp_tdo !== lfsr_prev[0]) begin errors++; $display("FAIL lfsr%0d_tdo: got %b required %b", i, rsp_tdo, lfsr_prev[0]); end
            checks++; if (rsp_chan !== ch)          begin errors++; $display("FAIL lfsr%0d_chan: got %b required %b", i, rsp_chan, ch); end
            $display("sample lfsr ch=%0d tdo=%b model=%b", ch, rsp_tdo, lfsr_prev[0]);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int hi;
        tdo_driven = 2'b11;
        tdo_data   = 2'b10;
        rsp_ready  = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        hi = 0;
        repeat (8) begin
            tick();
            if (cmd_ready) hi++;
        end
        checks++; if (hi != 0)            begin errors++; $display("FAIL stall_ready: got %0d ready cycles required 0", hi); end
        checks++; if (rsp_count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d required 2", rsp_count); end
        checks++; if (rsp_tdo !== 1'b1 || rsp_chan !== 1'b1) begin errors++; $display("FAIL stall_head: got tdo=%b chan=%b required tdo=1 chan=1", rsp_tdo, rsp_chan); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_count !== 2'd2) begin errors++; $display("FAIL pushpop_count: got %0d required 2", rsp_count); end
        checks++; if (rsp_tdo !== 1'b0 || rsp_chan !== 1'b0) begin errors++; $display("FAIL pushpop_head: got tdo=%b chan=%b required tdo=0 chan=0", rsp_tdo, rsp_chan); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL pushpop_ready: got %b required 1", cmd_ready); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_count !== 2'd1 || rsp_tdo !== 1'b1 || rsp_chan !== 1'b1) begin errors++; $display("FAIL drain1: got count=%0d tdo=%b chan=%b required 1/1/1", rsp_count, rsp_tdo, rsp_chan); end
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_count !== 2'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL drain2: got count=%0d valid=%b required 0/0", rsp_count, rsp_valid); end
        $display("test_back_to_back done: stalled ready cycles=%0d", hi);
    endtask

    task automatic test_enable();
        int hi, bad, n;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        enable = 1'b0;
        hi = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (cmd_ready) hi++;
            if (jtag_TCK !== 2'b01 || jtag_TMS !== 2'b01 || jtag_TDI !== 2'b01 || jtag_TRSTn !== 2'b11) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL enable_pins_stable: got %0d bad cycles required 0", bad); end
        checks++; if (hi != 0)  begin errors++; $display("FAIL enable_ready_low: got %0d ready cycles required 0", hi); end
        enable = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != TD + 1) begin errors++; $display("FAIL enable_resume: got %0d cycles required %0d", n, TD + 1); end
        checks++; if (jtag_TCK !== 2'b01 || jtag_TRSTn !== 2'b11) begin errors++; $display("FAIL enable_pins_end: got tck=%b trstn=%b required 01/11", jtag_TCK, jtag_TRSTn); end
        $display("test_enable done: resume cycles=%0d", n);
    endtask

    task automatic test_exit();
        int hi;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++; if (exit_val !== 32'd0) begin errors++; $display("FAIL exit0_value: got %0h required 0", exit_val); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL exit0_ready: got %b required 1", cmd_ready); end
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL exit0_next_accept: got ready=%b required 0", cmd_ready); end
        checks++; if (jtag_TCK !== 2'b11 || jtag_TMS !== 2'b01 || jtag_TDI !== 2'b01 || jtag_TRSTn !== 2'b11) begin
            errors++; $display("FAIL exit0_next_pins: got %b %b %b %b required 11 01 01 11", jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn);
        end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
        checks++; if (exit_val !== 32'h1) begin errors++; $display("FAIL exit1_value: got %0h required 1", exit_val); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL exit1_ready: got %b required 0", cmd_ready); end
        checks++; if (jtag_TCK !== 2'b11 || jtag_TRSTn !== 2'b11) begin errors++; $display("FAIL exit1_pins: got tck=%b trstn=%b required 11/11", jtag_TCK, jtag_TRSTn); end
        cmd_chan = 1'b0; cmd_tck = 1'b0; cmd_trstn = 1'b0; cmd_exit = 1'b0;
        cmd_valid = 1'b1;
        hi = 0;
        repeat (6) begin
            tick();
            if (cmd_ready) hi++;
        end
        cmd_valid = 1'b0;
        checks++; if (hi != 0)            begin errors++; $display("FAIL exit1_stays_closed: got %0d ready cycles required 0", hi); end
        checks++; if (exit_val !== 32'h1) begin errors++; $display("FAIL exit1_sticky: got %0h required 1", exit_val); end
        checks++; if (jtag_TCK !== 2'b11) begin errors++; $display("FAIL exit1_pins_after: got %b required 11", jtag_TCK); end
        $display("test_exit done: exit=%0h", exit_val);
    endtask

    task automatic test_async_reset();
        int n, hi;
        apply_reset();
        checks++; if (exit_val !== 32'd0) begin errors++; $display("FAIL rst_exit_clear: got %0h required 0", exit_val); end
        pulse_init();
        tdo_driven = 2'b01;
        tdo_data   = 2'b01;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        checks++; if (rsp_count !== 2'd1) begin errors++; $display("FAIL arst_pre_count: got %0d required 1", rsp_count); end
        issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        #3 reset = 1'b1;
        #1;
        checks++; if (jtag_TCK !== 2'b00 || jtag_TMS !== 2'b00 || jtag_TDI !== 2'b00 || jtag_TRSTn !== 2'b00) begin
            errors++; $display("FAIL arst_pins: got %b %b %b %b required all 00", jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn);
        end
        checks++; if (rsp_valid !== 1'b0 || rsp_count !== 2'd0) begin errors++; $display("FAIL arst_fifo: got valid=%b count=%0d required 0/0", rsp_valid, rsp_count); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b required 0", cmd_ready); end
        tick();
        reset = 1'b0;
        pulse_init();
        hi = 0;
        repeat (10) begin
            tick();
            if (rsp_valid) hi++;
        end
        checks++; if (hi != 0)            begin errors++; $display("FAIL arst_no_response: got %0d valid cycles required 0", hi); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_idle_after: got ready=%b required 1", cmd_ready); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sample_driven();
        test_sample_lfsr();
        test_back_to_back();
        test_enable();
        test_exit();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
